muldiv_unit: RTL and testbench

//   Iterative multiply/divide sequencer for the MIPS EX stage: owns the HI/LO registers and runs

---
 rtl/muldiv_unit_pkg.sv | 21 ++
 rtl/muldiv_unit_iter.sv | 46 ++++
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 tb/tb_muldiv_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared encodings for the multiply/divide unit
//   Operation codes (MD_OP_*), sequencer state encodings and default sizing.
package muldiv_unit_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 5;

  typedef enum logic [1:0] {
    MD_OP_MULT  = 2'd0,
    MD_OP_MULTU = 2'd1,
    MD_OP_DIV   = 2'd2,
    MD_OP_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_unit_iter.sv
// rtl/muldiv_unit_iter.sv - one combinational shift-add or restoring-divide step
//   i_is_div  : 1 = restoring divide step, 0 = shift-add multiply step
//   i_acc     : product high half / partial remainder
//   i_mq      : multiplier (shifting out) / dividend (shifting out, quotient shifting in)
//   i_opnd    : multiplicand / divisor magnitude
//   o_acc/o_mq: next-iteration values
module muldiv_unit_iter
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_mq,
  input  logic [WIDTH-1:0] i_opnd,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_mq
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  always_comb begin
    w_sum   = {1'b0, i_acc} + {1'b0, i_opnd};
    w_shift = {i_acc, i_mq[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, i_opnd});
    // Partial remainder is always below the divisor, so a kept difference fits WIDTH bits.
    w_diff  = w_shift[WIDTH-1:0] - i_opnd;
    o_acc   = '0;
    o_mq    = '0;
    if (i_is_div) begin
      o_acc = w_ge ? w_diff : w_shift[WIDTH-1:0];
      o_mq  = {i_mq[WIDTH-2:0], w_ge};
    end else if (i_mq[0]) begin
      // Carry out of the add becomes the new top bit of the 64-bit {acc,mq} pair.
      o_acc = w_sum[WIDTH:1];
      o_mq  = {w_sum[0], i_mq[WIDTH-1:1]};
    end else begin
      o_acc = {1'b0, i_acc[WIDTH-1:1]};
      o_mq  = {i_acc[0], i_mq[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO
//   i_clk, i_rst (async, active high)
//   i_start/i_op/i_a/i_b : launch an operation (accepted only when idle)
//   i_flush              : abort any in-flight operation, HI/LO untouched
//   i_hi_we/i_lo_we/i_wdata : MTHI/MTLO writes (accepted only when idle)
//   o_busy               : operation in flight
//   o_done               : one-cycle pulse after HI/LO take a result
//   o_hi/o_lo            : HI/LO registers
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_flush,
  input  logic             i_hi_we,
  input  logic             i_lo_we,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  md_state_e          r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div0;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_mq;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic               w_is_div;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]   w_mq_nxt;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;
  logic [2*WIDTH-1:0] w_prod_fix;

  assign w_signed = (i_op == MD_OP_MULT) || (i_op == MD_OP_DIV);
  assign w_is_div = (i_op == MD_OP_DIV) || (i_op == MD_OP_DIVU);
  assign w_a_neg  = w_signed & i_a[WIDTH-1];
  assign w_b_neg  = w_signed & i_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -i_a : i_a;
  assign w_b_mag  = w_b_neg ? -i_b : i_b;

  muldiv_unit_iter #(.WIDTH(WIDTH)) u_iter (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_mq     (r_mq),
    .i_opnd   (r_opnd),
    .o_acc    (w_acc_nxt),
    .o_mq     (w_mq_nxt)
  );

  // With a zero divisor every step keeps the subtraction, so the remainder ends
  // as |a|; giving it the sign of a restores the raw dividend for HI.
  assign w_prod_fix = r_neg_q ? -{r_acc, r_mq} : {r_acc, r_mq};
  assign w_q_fix    = r_neg_q ? -r_mq : r_mq;
  assign w_r_fix    = r_neg_r ? -r_acc : r_acc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_acc    <= '0;
      r_mq     <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_flush) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start) begin
              r_state  <= ST_RUN;
              r_busy   <= 1'b1;
              r_cnt    <= '0;
              r_is_div <= w_is_div;
              r_neg_q  <= w_a_neg ^ w_b_neg;
              r_neg_r  <= w_a_neg;
              r_div0   <= w_is_div && (i_b == '0);
              r_acc    <= '0;
              r_mq     <= w_is_div ? w_a_mag : w_b_mag;
              r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
            end else begin
              if (i_hi_we) r_hi <= i_wdata;
              if (i_lo_we) r_lo <= i_wdata;
            end
          end
          ST_RUN: begin
            r_acc <= w_acc_nxt;
            r_mq  <= w_mq_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_CNT) r_state <= ST_FIX;
          end
          ST_FIX: begin
            if (!r_is_div) begin
              r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
              r_lo <= w_prod_fix[WIDTH-1:0];
            end else begin
              r_hi <= w_r_fix;
              r_lo <= r_div0 ? '1 : w_q_fix;
            end
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [1:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_flush;
  logic        i_hi_we;
  logic        i_lo_we;
  logic [31:0] i_wdata;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  int n_checks = 0;
  int n_err    = 0;

  muldiv_unit dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_op    (i_op),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_flush (i_flush),
    .i_hi_we (i_hi_we),
    .i_lo_we (i_lo_we),
    .i_wdata (i_wdata),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_hi    (o_hi),
    .o_lo    (o_lo)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result {hi, lo} from MIPS rules using plain language arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint     sp;
    int         sa, sb, q, r;
    logic [63:0] up;
    case (op)
      2'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return 64'(sp);
      end
      2'd1: begin
        up = {32'b0, a} * {32'b0, b};
        return up;
      end
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        r  = sa % sb;
        return {32'(r), 32'(q)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Called n0 cycles after the start cycle; returns the cycle index of done (0 if none).
  task automatic wait_done(input int n0, output int lat, output bit busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    for (int n = n0; n <= 45; n++) begin
      if (o_busy !== 1'(n <= 33)) busy_ok = 1'b0;
      if (o_done === 1'b1) begin
        lat = n;
        break;
      end
      tick();
    end
  endtask

  // Starts in the current cycle, returns in the done cycle so ops can run back to back.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input string name);
    int lat;
    bit bok;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_hi_we = 1'b0;
    i_lo_we = 1'b0;
    i_op    = 2'($urandom);
    i_a     = $urandom;
    i_b     = $urandom;
    wait_done(1, lat, bok);
    check({name, " latency"}, 32'(lat), 32'd34);
    check({name, " busy"}, 32'(bok), 32'd1);
    check({name, " hi"}, o_hi, eh);
    check({name, " lo"}, o_lo, el);
  endtask

  vec_t vecs[10];

  initial begin
    int          lat;
    bit          bok;
    bit          saw;
    logic [63:0] m;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    vecs[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'd3, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4] = '{2'd3, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF};
    vecs[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    vecs[6] = '{2'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[7] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
    vecs[8] = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[9] = '{2'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};

    i_rst = 1'b1; i_start = 1'b0; i_op = 2'd0; i_a = '0; i_b = '0;
    i_flush = 1'b0; i_hi_we = 1'b0; i_lo_we = 1'b0; i_wdata = '0;
    repeat (3) tick();
    check("reset busy", 32'(o_busy), 32'd0);
    check("reset done", 32'(o_done), 32'd0);
    check("reset hi", o_hi, 32'd0);
    check("reset lo", o_lo, 32'd0);
    i_rst = 1'b0;
    tick();

    // directed vectors, issued back to back in each done cycle
    for (int i = 0; i < 10; i++)
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));
    tick();
    check("done width", 32'(o_done), 32'd0);
    check("idle busy", 32'(o_busy), 32'd0);

    // MTHI / MTLO, separately and together
    i_hi_we = 1'b1; i_wdata = 32'hA5A5_A5A5; tick();
    i_hi_we = 1'b0; i_lo_we = 1'b1; i_wdata = 32'h1111_1111; tick();
    i_lo_we = 1'b0;
    check("mthi", o_hi, 32'hA5A5_A5A5);
    check("mtlo", o_lo, 32'h1111_1111);
    i_hi_we = 1'b1; i_lo_we = 1'b1; i_wdata = 32'h5A5A_0F0F; tick();
    i_hi_we = 1'b0; i_lo_we = 1'b0;
    check("mt both hi", o_hi, 32'h5A5A_0F0F);
    check("mt both lo", o_lo, 32'h5A5A_0F0F);
    i_hi_we = 1'b1; i_wdata = 32'hA5A5_A5A5; tick();
    i_hi_we = 1'b0;

    // flush at T+10 of MULTU 2*3
    i_op = 2'd1; i_a = 32'd2; i_b = 32'd3; i_start = 1'b1; tick();
    i_start = 1'b0;
    for (int k = 2; k <= 10; k++) tick();
    check("flush pre busy", 32'(o_busy), 32'd1);
    i_flush = 1'b1; tick();
    i_flush = 1'b0;
    check("flush busy", 32'(o_busy), 32'd0);
    saw = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (o_done === 1'b1 || o_busy === 1'b1) saw = 1'b1;
      tick();
    end
    check("flush no done", 32'(saw), 32'd0);
    check("flush hi", o_hi, 32'hA5A5_A5A5);
    check("flush lo", o_lo, 32'h5A5A_0F0F);

    // flush and start together: start rejected
    i_op = 2'd1; i_a = 32'd4; i_b = 32'd4; i_start = 1'b1; i_flush = 1'b1; tick();
    i_start = 1'b0; i_flush = 1'b0;
    check("flush+start busy", 32'(o_busy), 32'd0);

    // start and MT writes while busy are ignored
    i_op = 2'd1; i_a = 32'd5; i_b = 32'd6; i_start = 1'b1; tick();
    i_start = 1'b0;
    tick(); tick();
    i_start = 1'b1; i_op = 2'd3; i_a = 32'd1; i_b = 32'd1;
    i_hi_we = 1'b1; i_lo_we = 1'b1; i_wdata = 32'hDEAD_BEEF; tick();
    i_start = 1'b0; i_hi_we = 1'b0; i_lo_we = 1'b0;
    wait_done(4, lat, bok);
    check("busy ign latency", 32'(lat), 32'd34);
    check("busy ign busy", 32'(bok), 32'd1);
    check("busy ign hi", o_hi, 32'd0);
    check("busy ign lo", o_lo, 32'd30);
    tick();
    check("busy ign no requeue", 32'(o_busy), 32'd0);

    // start wins over MT writes in the same idle cycle
    i_hi_we = 1'b1; i_lo_we = 1'b1; i_wdata = 32'hFFFF_0000;
    do_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, "start+mt");

    // randomized ops against the reference model, back to back
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if (i % 5 == 0) ra = 32'($urandom_range(0, 1000));
      m = model(rop, ra, rb);
      do_op(rop, ra, rb, m[63:32], m[31:0], $sformatf("rand%0d op%0d %h/%h", i, rop, ra, rb));
    end
    tick();

    // async reset between edges in the middle of RUN
    i_hi_we = 1'b1; i_lo_we = 1'b1; i_wdata = 32'h1357_2468; tick();
    i_hi_we = 1'b0; i_lo_we = 1'b0;
    i_op = 2'd1; i_a = 32'd9; i_b = 32'd9; i_start = 1'b1; tick();
    i_start = 1'b0;
    repeat (4) tick();
    #2 i_rst = 1'b1;
    #1;
    check("async rst busy", 32'(o_busy), 32'd0);
    check("async rst hi", o_hi, 32'd0);
    check("async rst lo", o_lo, 32'd0);
    #2 i_rst = 1'b0;
    tick();
    saw = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (o_done === 1'b1 || o_busy === 1'b1) saw = 1'b1;
      tick();
    end
    check("after rst quiet", 32'(saw), 32'd0);
    check("after rst lo", o_lo, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
